// File: rtl/pdm_pkg.sv
// Shared definitions for the PDM-to-PCM chain: frontend FSM states, default
// divider, the decimation ratio shared with the CIC stage, and the capture-point helper.
package pdm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2
  } pdm_state_e;

  localparam int DEF_CLK_DIV = 40;
  localparam int DECIM_RATIO = 64;

  // Capture point in div_cnt units; the left mic (channel 0) drives data after the falling edge.
  function automatic int cap_point(input int clk_div, input int sample_offset, input int channel);
    return sample_offset + ((channel == 0) ? clk_div / 2 : 0);
  endfunction

endpackage

// File: rtl/pdm_mic_frontend_if.sv
// Mic-side and decimator-side signals of the PDM frontend, bundled for the top-level port.
interface pdm_mic_frontend_if;

  logic enable;
  logic pdm_data_in;
  logic pdm_clk_out;
  logic sample_en;
  logic sampled_bit;
  logic mic_ready;

  modport master (
    input  enable,
    input  pdm_data_in,
    output pdm_clk_out,
    output sample_en,
    output sampled_bit,
    output mic_ready
  );

  modport slave (
    output enable,
    output pdm_data_in,
    input  pdm_clk_out,
    input  sample_en,
    input  sampled_bit,
    input  mic_ready
  );

endinterface

// File: rtl/pdm_mic_frontend_sync.sv
// Two-flop synchronizer for a single asynchronous bit, resetting to 0.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pdm_mic_frontend.sv
// PDM microphone frontend: generates the mic clock, synchronizes the data line and
// emits one sample strobe per mic-clock period after a warm-up interval.
module pdm_mic_frontend
  import pdm_pkg::*;
#(
  parameter int CLK_DIV        = DEF_CLK_DIV,
  parameter int SAMPLE_OFFSET  = 6,
  parameter int CHANNEL        = 0,
  parameter int WARMUP_PERIODS = 4096
) (
  input logic                clk,
  input logic                rst_n,
  pdm_mic_frontend_if.master bus
);

  localparam int HALF   = CLK_DIV / 2;
  localparam int CAP    = cap_point(CLK_DIV, SAMPLE_OFFSET, CHANNEL);
  localparam int DIV_W  = $clog2(CLK_DIV);
  localparam int WARM_W = $clog2(WARMUP_PERIODS + 1);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]  HALF_CNT  = DIV_W'(HALF);
  localparam logic [DIV_W-1:0]  CAP_CNT   = DIV_W'(CAP);
  localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(WARMUP_PERIODS - 1);
  localparam logic [WARM_W-1:0] WARM_MAX  = WARM_W'(WARMUP_PERIODS);

  if ((CLK_DIV % 2) != 0 || CLK_DIV < 4) begin : g_bad_clk_div
    $error("pdm_mic_frontend: CLK_DIV must be even and >= 4");
  end
  if (SAMPLE_OFFSET < 0 || SAMPLE_OFFSET >= HALF) begin : g_bad_offset
    $error("pdm_mic_frontend: SAMPLE_OFFSET must be in 0..CLK_DIV/2-1");
  end
  if (CHANNEL != 0 && CHANNEL != 1) begin : g_bad_channel
    $error("pdm_mic_frontend: CHANNEL must be 0 or 1");
  end
  if (WARMUP_PERIODS < 1) begin : g_bad_warmup
    $error("pdm_mic_frontend: WARMUP_PERIODS must be >= 1");
  end

  pdm_state_e        state_q, state_nxt;
  logic [DIV_W-1:0]  div_cnt, div_cnt_nxt;
  logic [WARM_W-1:0] warm_cnt, warm_cnt_nxt;
  logic              pdm_clk_q, pdm_clk_nxt;
  logic              sample_en_q, sample_en_nxt;
  logic              mic_ready_q, mic_ready_nxt;
  logic              sampled_bit_q;
  logic              sync_d;
  logic              wrap;

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bus.pdm_data_in),
    .q     (sync_d)
  );

  assign wrap = (div_cnt == DIV_LAST);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  // NOTE: every combinational output gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state_q;
    if (!bus.enable) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:   state_nxt = ST_WARMUP;
        ST_WARMUP: if (wrap && warm_cnt == WARM_LAST) state_nxt = ST_RUN;
        ST_RUN:    state_nxt = ST_RUN;
        default:   state_nxt = ST_IDLE;
      endcase
    end
  end

  // Dropping enable zeroes every next value, so an abandoned period never strobes.
  always_comb begin
    div_cnt_nxt   = '0;
    warm_cnt_nxt  = '0;
    pdm_clk_nxt   = 1'b0;
    sample_en_nxt = 1'b0;
    mic_ready_nxt = (state_nxt == ST_RUN);
    if (bus.enable && state_q != ST_IDLE) begin
      div_cnt_nxt  = wrap ? '0 : div_cnt + 1'b1;
      warm_cnt_nxt = warm_cnt;
      if (wrap && warm_cnt != WARM_MAX) warm_cnt_nxt = warm_cnt + 1'b1;
      pdm_clk_nxt   = (div_cnt < HALF_CNT);
      sample_en_nxt = (state_q == ST_RUN) && (div_cnt == CAP_CNT);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt       <= '0;
      warm_cnt      <= '0;
      pdm_clk_q     <= 1'b0;
      sample_en_q   <= 1'b0;
      mic_ready_q   <= 1'b0;
      sampled_bit_q <= 1'b0;
    end else begin
      div_cnt     <= div_cnt_nxt;
      warm_cnt    <= warm_cnt_nxt;
      pdm_clk_q   <= pdm_clk_nxt;
      sample_en_q <= sample_en_nxt;
      mic_ready_q <= mic_ready_nxt;
      if (sample_en_nxt) sampled_bit_q <= sync_d;
    end
  end

  assign bus.pdm_clk_out = pdm_clk_q;
  assign bus.sample_en   = sample_en_q;
  assign bus.sampled_bit = sampled_bit_q;
  assign bus.mic_ready   = mic_ready_q;

endmodule

// File: tb/tb_pdm_mic_frontend.sv
// Directed bench for pdm_mic_frontend: one instance per channel (CLK_DIV=8,
// SAMPLE_OFFSET=3, WARMUP_PERIODS=4), expected values computed by hand.
module tb_pdm_mic_frontend;

  localparam int DIV  = 8;
  localparam int WARM = 4;
  localparam int RUN_EDGE = DIV * WARM + 1;  // edge after enable at which RUN is entered

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  pdm_mic_frontend_if if0 ();
  pdm_mic_frontend_if if1 ();

  pdm_mic_frontend #(.CLK_DIV(DIV), .SAMPLE_OFFSET(3), .CHANNEL(0), .WARMUP_PERIODS(WARM)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
  );

  pdm_mic_frontend #(.CLK_DIV(DIV), .SAMPLE_OFFSET(3), .CHANNEL(1), .WARMUP_PERIODS(WARM)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
  );

  logic [1:0] pclk, sen, sbit, rdy;
  assign pclk = {if1.pdm_clk_out, if0.pdm_clk_out};
  assign sen  = {if1.sample_en,   if0.sample_en};
  assign sbit = {if1.sampled_bit, if0.sampled_bit};
  assign rdy  = {if1.mic_ready,   if0.mic_ready};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_en(input bit ch, input logic v);
    if (ch) if1.enable = v;
    else    if0.enable = v;
  endtask

  task automatic set_data(input bit ch, input logic v);
    if (ch) if1.pdm_data_in = v;
    else    if0.pdm_data_in = v;
  endtask

  // Enable the channel and follow the full warm-up: clock pattern, no strobes,
  // mic_ready rising exactly on the WARM-th wrap.
  task automatic run_warmup(input bit ch);
    set_en(ch, 1'b1);
    tick();
    check($sformatf("ch%0d_first_clk", ch), pclk[ch], 1'b0);
    check($sformatf("ch%0d_first_rdy", ch), rdy[ch], 1'b0);
    for (int k = 2; k <= RUN_EDGE; k++) begin
      tick();
      check($sformatf("ch%0d_warm_clk_%0d", ch, k), pclk[ch], ((k - 2) % DIV) < (DIV / 2));
      check($sformatf("ch%0d_warm_sen_%0d", ch, k), sen[ch], 1'b0);
      check($sformatf("ch%0d_warm_rdy_%0d", ch, k), rdy[ch], k >= RUN_EDGE);
    end
  endtask

  initial begin
    logic [3:0] pat0;
    logic [3:0] pat1;
    logic       prev;
    n_checks = 0;
    n_fail   = 0;
    pat0     = 4'b1101;  // applied LSB first: 1,0,1,1
    pat1     = 4'b1001;  // applied LSB first: 1,0,0,1
    rst_n    = 1'b0;
    if0.enable = 1'b0;  if0.pdm_data_in = 1'b0;
    if1.enable = 1'b0;  if1.pdm_data_in = 1'b0;

    // Reset values.
    #2;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("rst_clk_%0d", c), pclk[c], 1'b0);
      check($sformatf("rst_sen_%0d", c), sen[c], 1'b0);
      check($sformatf("rst_bit_%0d", c), sbit[c], 1'b0);
      check($sformatf("rst_rdy_%0d", c), rdy[c], 1'b0);
    end
    #10 rst_n = 1'b1;

    // Idle with enable low: everything stays quiet.
    for (int i = 0; i < 100; i++) begin
      tick();
      if0.pdm_data_in = i[0];
      if1.pdm_data_in = i[1];
      check($sformatf("idle_clk_%0d", i), |pclk, 1'b0);
      check($sformatf("idle_sen_%0d", i), |sen, 1'b0);
      check($sformatf("idle_rdy_%0d", i), |rdy, 1'b0);
    end
    if0.pdm_data_in = 1'b0;
    if1.pdm_data_in = 1'b0;

    // Channel 0: warm-up, then one strobe per 8 cycles at div_cnt 7 (+1).
    run_warmup(1'b0);
    prev = 1'b0;
    for (int p = 0; p < 4; p++) begin
      set_data(1'b0, pat0[p]);
      for (int i = 1; i < DIV; i++) begin
        tick();
        check($sformatf("ch0_gap_sen_p%0d_%0d", p, i), sen[0], 1'b0);
        check($sformatf("ch0_gap_bit_p%0d_%0d", p, i), sbit[0], prev);
      end
      tick();
      check($sformatf("ch0_strobe_p%0d", p), sen[0], 1'b1);
      check($sformatf("ch0_bit_p%0d", p), sbit[0], pat0[p]);
      prev = pat0[p];
    end

    // Enable dropped mid-period while the mic clock is high.
    tick();
    tick();
    check("ch0_mid_clk_before", pclk[0], 1'b1);
    set_en(1'b0, 1'b0);
    tick();
    check("ch0_mid_clk", pclk[0], 1'b0);
    check("ch0_mid_rdy", rdy[0], 1'b0);
    check("ch0_mid_sen", sen[0], 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("ch0_off_sen_%0d", i), sen[0], 1'b0);
      check($sformatf("ch0_off_clk_%0d", i), pclk[0], 1'b0);
    end

    // Re-enable: full warm-up again, then drop enable in the CAP cycle.
    run_warmup(1'b0);
    for (int i = 1; i < DIV; i++) begin
      tick();
      check($sformatf("ch0_precap_sen_%0d", i), sen[0], 1'b0);
    end
    set_en(1'b0, 1'b0);
    tick();
    check("ch0_cap_drop_sen", sen[0], 1'b0);
    check("ch0_cap_drop_clk", pclk[0], 1'b0);
    check("ch0_cap_drop_rdy", rdy[0], 1'b0);
    for (int i = 0; i < DIV; i++) begin
      tick();
      check($sformatf("ch0_cap_off_sen_%0d", i), sen[0], 1'b0);
    end

    // Re-enable once more: first strobe only after the whole warm-up.
    run_warmup(1'b0);
    set_data(1'b0, 1'b0);
    for (int i = 1; i < DIV; i++) begin
      tick();
      check($sformatf("ch0_rearm_gap_%0d", i), sen[0], 1'b0);
    end
    tick();
    check("ch0_rearm_strobe", sen[0], 1'b1);
    check("ch0_rearm_bit", sbit[0], 1'b0);

    // Channel 1: strobe at div_cnt 3 (+1); data in the low half is ignored.
    run_warmup(1'b1);
    prev = 1'b0;
    for (int p = 0; p < 4; p++) begin
      set_data(1'b1, pat1[p]);
      for (int i = 1; i < 4; i++) begin
        tick();
        check($sformatf("ch1_pre_sen_p%0d_%0d", p, i), sen[1], 1'b0);
        check($sformatf("ch1_pre_bit_p%0d_%0d", p, i), sbit[1], prev);
      end
      tick();
      check($sformatf("ch1_strobe_p%0d", p), sen[1], 1'b1);
      check($sformatf("ch1_bit_p%0d", p), sbit[1], pat1[p]);
      set_data(1'b1, ~pat1[p]);
      for (int i = 0; i < 4; i++) begin
        tick();
        check($sformatf("ch1_low_sen_p%0d_%0d", p, i), sen[1], 1'b0);
        check($sformatf("ch1_low_bit_p%0d_%0d", p, i), sbit[1], pat1[p]);
      end
      prev = pat1[p];
    end

    // Asynchronous reset in RUN, between clock edges.
    check("ch1_pre_reset_rdy", rdy[1], 1'b1);
    check("ch1_pre_reset_bit", sbit[1], 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int c = 0; c < 2; c++) begin
      check($sformatf("arst_clk_%0d", c), pclk[c], 1'b0);
      check($sformatf("arst_sen_%0d", c), sen[c], 1'b0);
      check($sformatf("arst_bit_%0d", c), sbit[c], 1'b0);
      check($sformatf("arst_rdy_%0d", c), rdy[c], 1'b0);
    end
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rdy_0", rdy[0], 1'b0);
    check("post_rst_rdy_1", rdy[1], 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pdm_mic_frontend.md
Name: pdm_mic_frontend

Overview:
- Upstream stage of the PDM-to-PCM chain. Generates the PDM microphone clock from the system clock and synchronizes the mic data line.
- Samples one channel at a programmed point after the selected mic-clock edge. Emits a one-cycle sample_en strobe with the sampled_bit, feeding the CIC decimator's sample_en/sampled_bit inputs directly.
- Runs a warm-up period after enable, during which strobes are suppressed, so the mic's start-up transient never reaches the decimator.

Parameters:
- CLK_DIV, 40, clk cycles per PDM clock period. Must be even and >=4; 100 MHz/40 = 2.5 MHz.
- SAMPLE_OFFSET, 6, clk cycles after the selected PDM edge at which the synchronized data is captured. Range 0..CLK_DIV/2-1. Already accounts for the 2-cycle synchronizer latency.
- CHANNEL, 0, edge selection. 0 = capture relative to the falling edge (left mic, L/R tied low). 1 = capture relative to the rising edge.
- WARMUP_PERIODS, 4096, number of full PDM clock periods after enable during which sample_en is suppressed. Must be >=1.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- enable  input  1  level; 1 = run mic clock and sampling
- pdm_data_in  input  1  raw mic data line, asynchronous to clk
- pdm_clk_out  output  1  mic clock, registered, 50% duty
- sample_en  output  1  one-clk strobe, one per PDM period once ready
- sampled_bit  output  1  captured PDM bit; valid when sample_en=1, held otherwise
- mic_ready  output  1  high once warm-up has completed and while enable stays high

Behaviour:
- Reset (rst_n=0, async):
  - State=IDLE; div_cnt=0; warm_cnt=0.
  - pdm_clk_out=0, sample_en=0, sampled_bit=0, mic_ready=0.
  - Both synchronizer flops = 0.
- Synchronizer: pdm_data_in passes through 2 flops (sync_d) every cycle, in all states.
- Divider: div_cnt counts 0..CLK_DIV-1 and wraps; it advances only in WARMUP and RUN.
- Clock output: pdm_clk_out is registered and equals 1 while div_cnt < CLK_DIV/2.
  - Rising edge is at div_cnt 0; falling edge is at div_cnt CLK_DIV/2.
  - In IDLE it is forced to 0.
- Capture point:
  - CAP = SAMPLE_OFFSET + (CHANNEL==0 ? CLK_DIV/2 : 0).
  - When div_cnt==CAP in RUN: on the next clk, sampled_bit<=sync_d and sample_en<=1 for exactly one cycle.
  - In all other cycles sample_en=0 and sampled_bit holds.
- FSM states: IDLE, WARMUP, RUN.
  - IDLE: div_cnt held at 0. If enable=1, go to WARMUP next cycle with warm_cnt=0; the first pdm_clk_out rise follows one cycle later.
  - WARMUP:
    - warm_cnt increments on each div_cnt wrap (CLK_DIV-1 -> 0).
    - When a wrap occurs with warm_cnt==WARMUP_PERIODS-1, go to RUN.
    - No sample_en in this state, even if div_cnt passes CAP.
  - RUN: mic_ready=1 (registered, asserted the cycle RUN is entered); strobes issued as above.
  - Any state, enable=0: next cycle state=IDLE, div_cnt=0, pdm_clk_out=0, mic_ready=0, sample_en=0. The period in progress is abandoned and no partial strobe is issued.
    - If enable falls in the same cycle that div_cnt==CAP, no strobe is issued.
    - Re-enable restarts the full warm-up.
- Rate: in RUN, exactly one strobe per CLK_DIV cycles, spaced CLK_DIV apart. The downstream decimation count therefore stays aligned.
- Widths:
  - div_cnt = $clog2(CLK_DIV).
  - warm_cnt = $clog2(WARMUP_PERIODS+1). It saturates and never wraps.
- Static checks: parameter violations (odd CLK_DIV, SAMPLE_OFFSET >= CLK_DIV/2) are flagged by elaboration-time assertions.

Decomposition:
- Package pdm_pkg holds:
  - the state enum (IDLE/WARMUP/RUN);
  - default CLK_DIV;
  - the decimation ratio constant (64) shared with the decimator;
  - a localparam function computing CAP.
- One sub-module: sync_2ff (1-bit, async active-low reset, reset value 0), instantiated for pdm_data_in.

Test Plan:
- Reset/idle: rst_n=0 then 1, enable=0 for 100 cycles -> pdm_clk_out=0, sample_en=0, mic_ready=0 throughout.
- Clock generation (CLK_DIV=8, WARMUP_PERIODS=4): enable=1 -> pdm_clk_out period 8, high 4 / low 4 cycles. Zero sample_en during the first 32 clk of clocking. mic_ready rises exactly at the 4th wrap.
- Capture timing, CHANNEL=0, SAMPLE_OFFSET=3, CLK_DIV=8:
  - pdm_data_in toggles 1 cycle after each falling edge -> sample_en pulses once per 8 cycles, at div_cnt==7 (+1 register).
  - sampled_bit equals the level driven in that period.
  - Pattern 1,0,1,1 yields sampled_bit 1,0,1,1.
- CHANNEL=1 with the same offset -> strobes at div_cnt 3+1. Data driven only during the clock-high half is captured; data during the low half is ignored.
- Enable drop mid-period and at the CAP cycle -> no strobe, pdm_clk_out=0 the next cycle, mic_ready=0. Re-enable -> full warm-up of 4 periods again before the first strobe.
- Async reset asserted mid-RUN -> all outputs 0 immediately, without waiting for a clk edge. With an end-to-end decimator hookup and all-ones data, the decimator delivers pcm_valid once every 64 strobes.
